// File: rtl/timer_dev_if.sv
// Data-bus bundle between the core's M stage and the interval timer.
// The core drives address/data/byte enables; the timer returns read data and its interrupt.
interface timer_dev_if;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
    logic [31:0] rdata;
    logic        irq;

    modport master (
        output addr,
        output wdata,
        output byteen,
        input  rdata,
        input  irq
    );

    modport slave (
        input  addr,
        input  wdata,
        input  byteen,
        output rdata,
        output irq
    );
endinterface

// File: rtl/timer_dev.sv
// Memory-mapped interval timer: CTRL/PRESET/COUNT registers, a four-state counting FSM,
// one-shot and auto-reload modes, and a registered interrupt request for CP0.
module timer_dev #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_7F00
) (
    input  logic       clk,
    input  logic       reset,
    timer_dev_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_CNT,
        S_INT
    } state_e;

    localparam logic [29:0] CTRL_WORD   = BASE_ADDR[31:2];
    localparam logic [29:0] PRESET_WORD = CTRL_WORD + 30'd1;
    localparam logic [29:0] COUNT_WORD  = CTRL_WORD + 30'd2;
    localparam logic [1:0]  MODE_RELOAD = 2'b01;
    localparam int          EN_BIT      = 0;
    localparam int          IM_BIT      = 3;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        flag_q, flag_d;
    logic        irq_q, irq_d;

    logic [29:0] wordAddr;
    logic        hitCtrl, hitPreset, hitCount;
    logic        busWrite, wrCtrl, wrPreset;
    logic        enable, oneShot, fsmClearEn;
    logic [31:0] readMux;

    assign wordAddr  = bus.addr[31:2];
    assign hitCtrl   = (wordAddr == CTRL_WORD);
    assign hitPreset = (wordAddr == PRESET_WORD);
    assign hitCount  = (wordAddr == COUNT_WORD);
    assign busWrite  = |bus.byteen;
    assign wrCtrl    = hitCtrl & busWrite;
    assign wrPreset  = hitPreset & busWrite;
    assign enable    = ctrl_q[EN_BIT];
    assign oneShot   = (ctrl_q[2:1] != MODE_RELOAD);

    wire unused_ok = &{1'b0, bus.addr[1:0]};

    // An FSM flag set outranks a one-shot bus clear arriving on the same edge.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        flag_d     = flag_q;
        fsmClearEn = 1'b0;

        if ((wrCtrl || wrPreset) && oneShot) begin
            flag_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                count_d = preset_q;
                state_d = S_CNT;
            end
            S_CNT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (count_q == 32'd0) begin
                    flag_d  = 1'b1;
                    state_d = S_INT;
                end else begin
                    count_d = count_q - 32'd1;
                end
            end
            S_INT: begin
                state_d = S_IDLE;
                if (oneShot) begin
                    fsmClearEn = 1'b1;
                end else begin
                    flag_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // CTRL fields all live in byte lane 0, so only byteen[0] can change them.
    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;

        if (fsmClearEn) begin
            ctrl_d[EN_BIT] = 1'b0;
        end
        if (wrCtrl && bus.byteen[0]) begin
            ctrl_d = bus.wdata[3:0];
        end

        for (int i = 0; i < 4; i++) begin
            if (wrPreset && bus.byteen[i]) begin
                preset_d[8*i +: 8] = bus.wdata[8*i +: 8];
            end
        end
    end

    assign irq_d = flag_d & ctrl_d[IM_BIT];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ctrl_q   <= 4'd0;
            preset_q <= 32'd0;
            count_q  <= 32'd0;
            flag_q   <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            flag_q   <= flag_d;
            irq_q    <= irq_d;
        end
    end

    always_comb begin
        readMux = 32'd0;
        if (hitCtrl) begin
            readMux = {28'd0, ctrl_q};
        end else if (hitPreset) begin
            readMux = preset_q;
        end else if (hitCount) begin
            readMux = count_q;
        end
    end

    assign bus.rdata = readMux;
    assign bus.irq   = irq_q;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register-access vector table, hand-timed corner
// sequences, and a randomized run checked against an elapsed-cycle model of the timer.
module tb_timer_dev;

    localparam logic [31:0] BASE     = 32'h0000_7F00;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_PRESET = BASE + 32'd4;
    localparam logic [31:0] A_COUNT  = BASE + 32'd8;
    localparam logic [31:0] A_MISS1  = BASE + 32'd12;
    localparam logic [31:0] A_MISS2  = BASE - 32'd4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    timer_dev_if bus ();

    timer_dev #(.BASE_ADDR(BASE)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] expRd;
        logic        expIrq;
    } vec_t;

    vec_t vecs[15];

    // Reference model: the run is tracked by its age in cycles since leaving idle
    // (-1 idle, 0 loading, 1..L+1 counting down from L, L+2 expiry cycle).
    longint      mAge;
    logic [31:0] mLoad, mCount, mPreset;
    logic [3:0]  mCtrl;
    logic        mFlag, mIrq;

    task automatic modelReset();
        mAge = -1; mLoad = 0; mCount = 0; mPreset = 0;
        mCtrl = 0; mFlag = 0; mIrq = 0;
    endtask

    function automatic logic [31:0] modelRead(input logic [31:0] a);
        if (a[31:2] == A_CTRL[31:2])   return {28'd0, mCtrl};
        if (a[31:2] == A_PRESET[31:2]) return mPreset;
        if (a[31:2] == A_COUNT[31:2])  return mCount;
        return 32'd0;
    endfunction

    task automatic modelStep(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        logic        hitC, hitP, single;
        longint      nAge;
        logic [31:0] nLoad, nCount, nPreset;
        logic [3:0]  nCtrl;
        logic        nFlag;
        hitC = (be != 0) && (a[31:2] == A_CTRL[31:2]);
        hitP = (be != 0) && (a[31:2] == A_PRESET[31:2]);
        single = (mCtrl[2:1] != 2'b01);
        nAge = mAge; nLoad = mLoad; nCount = mCount; nPreset = mPreset;
        nCtrl = mCtrl; nFlag = mFlag;
        if ((hitC || hitP) && single) nFlag = 1'b0;
        if (mAge < 0) begin
            if (mCtrl[0]) nAge = 0;
        end else if (mAge == 0) begin
            nLoad = mPreset; nCount = mPreset; nAge = 1;
        end else if (mAge <= longint'(mLoad) + 1) begin
            if (!mCtrl[0]) nAge = -1;
            else begin
                nAge = mAge + 1;
                if (nAge == longint'(mLoad) + 2) nFlag = 1'b1;
                else nCount = mLoad - 32'(nAge - 1);
            end
        end else begin
            nAge = -1;
            if (single) nCtrl[0] = 1'b0;
            else nFlag = 1'b0;
        end
        if (hitC && be[0]) nCtrl = wd[3:0];
        if (hitP) begin
            for (int i = 0; i < 4; i++)
                if (be[i]) nPreset[8*i +: 8] = wd[8*i +: 8];
        end
        mAge = nAge; mLoad = nLoad; mCount = nCount; mPreset = nPreset;
        mCtrl = nCtrl; mFlag = nFlag; mIrq = nFlag & nCtrl[3];
    endtask

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic checkIrq(input string name, input logic exp);
        checkOutput(name, {31'd0, bus.irq}, {31'd0, exp});
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
        bus.addr = a; bus.wdata = wd; bus.byteen = be;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic writeReg(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        applyStimulus(a, d, be);
        step();
        applyStimulus(a, 32'd0, 4'd0);
    endtask

    task automatic readCheck(input string name, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(a, 32'd0, 4'd0);
        #1;
        checkOutput(name, bus.rdata, exp);
    endtask

    task automatic doReset();
        applyStimulus(A_CTRL, 32'd0, 4'd0);
        reset = 1'b1;
        #2;
        step();
        reset = 1'b0;
        modelReset();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] ra, rw;
        logic [3:0]  rb;
        int          sel;

        applyStimulus(A_CTRL, 32'd0, 4'd0);
        #2 reset = 1'b1;
        #1;
        checkIrq("reset irq", 1'b0);
        readCheck("reset ctrl", A_CTRL, 32'd0);
        readCheck("reset preset", A_PRESET, 32'd0);
        readCheck("reset count", A_COUNT, 32'd0);
        step();
        reset = 1'b0;

        vecs[0]  = '{"preset full write",  A_PRESET, 32'h1122_3344, 4'hF, 32'h0000_0000, 1'b0};
        vecs[1]  = '{"preset byte merge",  A_PRESET, 32'hAABB_CCDD, 4'h5, 32'h1122_3344, 1'b0};
        vecs[2]  = '{"preset merged read", A_PRESET, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[3]  = '{"count write",        A_COUNT,  32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{"count read only",    A_COUNT,  32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[5]  = '{"miss above write",   A_MISS1,  32'hFFFF_FFFF, 4'hF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{"miss below write",   A_MISS2,  32'h1234_5678, 4'h3, 32'h0000_0000, 1'b0};
        vecs[7]  = '{"preset after miss",  A_PRESET, 32'h0,         4'h0, 32'h11BB_33DD, 1'b0};
        vecs[8]  = '{"ctrl after miss",    A_CTRL,   32'h0,         4'h0, 32'h0000_0000, 1'b0};
        vecs[9]  = '{"ctrl upper ignored", A_CTRL,   32'hFFFF_FFF6, 4'hF, 32'h0000_0000, 1'b0};
        vecs[10] = '{"ctrl low field",     A_CTRL,   32'h0,         4'h0, 32'h0000_0006, 1'b0};
        vecs[11] = '{"ctrl lane0 off",     A_CTRL,   32'h0,         4'hE, 32'h0000_0006, 1'b0};
        vecs[12] = '{"ctrl kept",          A_CTRL,   32'h0,         4'h0, 32'h0000_0006, 1'b0};
        vecs[13] = '{"ctrl clear",         A_CTRL,   32'h0,         4'hF, 32'h0000_0006, 1'b0};
        vecs[14] = '{"ctrl cleared",       A_CTRL,   32'h0,         4'h0, 32'h0000_0000, 1'b0};

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i].addr, vecs[i].wdata, vecs[i].be);
            #1;
            checkOutput(vecs[i].name, bus.rdata, vecs[i].expRd);
            checkIrq({vecs[i].name, " irq"}, vecs[i].expIrq);
            step();
        end

        // One-shot, PRESET=5: irq after E8, EN cleared after E9, CTRL write drops irq.
        doReset();
        writeReg(A_PRESET, 32'd5, 4'hF);
        writeReg(A_CTRL, 32'h9, 4'hF);
        step(); step();
        readCheck("oneshot count loaded", A_COUNT, 32'd5);
        for (int k = 3; k <= 8; k++) begin
            step();
            checkIrq($sformatf("oneshot irq E%0d", k), k == 8);
        end
        step();
        readCheck("oneshot ctrl en cleared", A_CTRL, 32'h8);
        for (int k = 0; k < 3; k++) begin
            step();
            checkIrq("oneshot irq held", 1'b1);
        end
        writeReg(A_CTRL, 32'h0, 4'hF);
        checkIrq("oneshot irq dropped", 1'b0);

        // PRESET=0 run, then an asynchronous reset pulse mid-cycle while irq is high.
        doReset();
        writeReg(A_CTRL, 32'h9, 4'hF);
        step(); checkIrq("zero preset irq E1", 1'b0);
        step(); checkIrq("zero preset irq E2", 1'b0);
        step(); checkIrq("zero preset irq E3", 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        checkIrq("async reset irq", 1'b0);
        readCheck("async reset ctrl", A_CTRL, 32'd0);
        readCheck("async reset count", A_COUNT, 32'd0);
        #1 reset = 1'b0;
        step();
        checkIrq("after async reset irq", 1'b0);

        // Auto-reload, PRESET=3: one-cycle pulse after E6, E13, E20.
        doReset();
        writeReg(A_PRESET, 32'd3, 4'hF);
        writeReg(A_CTRL, 32'hB, 4'hF);
        for (int k = 1; k <= 22; k++) begin
            step();
            checkIrq($sformatf("reload irq E%0d", k), (k == 6) || (k == 13) || (k == 20));
        end
        readCheck("reload en kept", A_CTRL, 32'hB);

        // Clear EN while COUNT reads 5; the edge takes it to 4 where it freezes.
        doReset();
        writeReg(A_PRESET, 32'd10, 4'hF);
        writeReg(A_CTRL, 32'h9, 4'hF);
        repeat (7) step();
        readCheck("disable count before", A_COUNT, 32'd5);
        writeReg(A_CTRL, 32'h8, 4'hF);
        for (int k = 0; k < 15; k++) begin
            step();
            readCheck("disable count frozen", A_COUNT, 32'd4);
            checkIrq("disable no irq", 1'b0);
        end

        // Masked one-shot: flag sets silently; the IM-setting CTRL write also clears it.
        doReset();
        writeReg(A_PRESET, 32'd2, 4'hF);
        writeReg(A_CTRL, 32'h1, 4'hF);
        for (int k = 1; k <= 8; k++) begin
            step();
            checkIrq("masked irq", 1'b0);
        end
        readCheck("masked en cleared", A_CTRL, 32'h0);
        writeReg(A_CTRL, 32'h8, 4'hF);
        checkIrq("unmask same edge", 1'b0);
        for (int k = 0; k < 3; k++) begin
            step();
            checkIrq("unmask stays low", 1'b0);
        end
        readCheck("unmask ctrl", A_CTRL, 32'h8);

        // Reset mid-count with PRESET=100 around COUNT=50.
        doReset();
        writeReg(A_PRESET, 32'd100, 4'hF);
        writeReg(A_CTRL, 32'h9, 4'hF);
        repeat (52) step();
        readCheck("midcount count", A_COUNT, 32'd50);
        #1 reset = 1'b1;
        #1;
        checkIrq("midcount reset irq", 1'b0);
        readCheck("midcount reset ctrl", A_CTRL, 32'd0);
        readCheck("midcount reset preset", A_PRESET, 32'd0);
        readCheck("midcount reset count", A_COUNT, 32'd0);
        step();
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            readCheck("post reset count", A_COUNT, 32'd0);
            readCheck("post reset ctrl", A_CTRL, 32'd0);
            checkIrq("post reset irq", 1'b0);
        end

        // Randomized traffic against the reference model.
        doReset();
        for (int i = 0; i < 600; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 3)      ra = A_CTRL;
            else if (sel <= 6) ra = A_PRESET;
            else if (sel <= 8) ra = A_COUNT;
            else               ra = ($urandom_range(0, 1) == 0) ? A_MISS1 : A_MISS2;
            rb = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            if (ra == A_CTRL)
                rw = ($urandom & 32'hFFFF_FFF0) | 32'($urandom_range(0, 7) << 1)
                     | 32'($urandom_range(0, 3) != 0);
            else
                rw = 32'($urandom_range(0, 10));
            applyStimulus(ra, rw, rb);
            #1;
            checkOutput("rand rdata", bus.rdata, modelRead(ra));
            checkIrq("rand irq", mIrq);
            modelStep(ra, rw, rb);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/timer_dev.md
# timer_dev

Memory-mapped interval timer sitting on the CPU data bus beside data memory. It answers the `m_data_*` write/read interface driven by the pipelined MIPS core, and it is the source of the `interrupt` line the core's CP0 consumes. It provides three word registers (CTRL, PRESET, COUNT), a 4-state counting FSM, and one-shot and auto-reload modes.

## Interface
- `BASE_ADDR`, 32'h0000_7F00: word-aligned base address. CTRL = BASE+0, PRESET = BASE+4, COUNT = BASE+8.
- `clk` input 1: single clock. All state changes on its rising edge.
- `reset` input 1: asynchronous, active-high reset.
- `addr` input 32: byte address from the M stage. Bits [1:0] are ignored for decode.
- `wdata` input 32: write data, already lane-shifted by the core.
- `byteen` input 4: byte write enables. Nonzero with an address hit means a write.
- `rdata` output 32: combinational read of the addressed register. Reads 0 on a miss.
- `irq` output 1: registered interrupt request to the core.

## Operation
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload, 1x treated as one-shot.
  - [3] IM: interrupt mask, 1 = allow `irq`.
  - [31:4] read as 0 and ignore writes.
- PRESET: 32-bit read/write.
- COUNT: 32-bit, read-only. Bus writes to it are ignored.
- Writes merge per byte. Only the lanes with `byteen[i]` set are updated; the other lanes keep their old value.
- FSM states and transitions:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET, go to CNT.
  - CNT:
    - EN=0: go to IDLE, COUNT holds.
    - COUNT==0: set the flag, go to INT.
    - Otherwise COUNT <= COUNT-1.
  - INT:
    - Mode 00/1x: clear EN, go to IDLE. The flag stays set.
    - Mode 01: clear the flag, go to IDLE. EN stays 1, so the timer reloads.
- `irq` = flag & IM, held in a register.
- In one-shot mode the flag clears on any bus write to CTRL or PRESET.
- Same-cycle bus write to CTRL and FSM clear of EN: the bus value wins.
- A PRESET write while counting does not affect the current COUNT. It takes effect at the next LOAD.
- COUNT wraps nowhere. It stops at 0.
- PRESET = 0 is legal: LOAD → CNT → INT, with the flag set 1 cycle after CNT is entered.
- Reset, asynchronous and at any point including mid-count:
  - CTRL = 0, PRESET = 0, COUNT = 0.
  - State = IDLE, flag = 0, `irq` = 0.
  - `rdata` follows the cleared registers immediately.

## Timing
- Register writes land at the edge where `byteen` is nonzero. A read of the same address shows the new value in the next cycle.
- `rdata` has no latency: it is a mux of the current register values.
- Edge E0 writes EN=1. The FSM sees EN in IDLE during cycle 1.
  - E1: enter LOAD.
  - E2: COUNT = P, enter CNT.
  - E2+P: COUNT = 0.
  - E3+P: flag set, enter INT. `irq` is high after this edge.
- One-shot: `irq` stays high until a CTRL/PRESET write or reset. EN reads 0 from E4+P on.
- Auto-reload: `irq` is a 1-cycle pulse with period P+4 cycles (INT, IDLE, LOAD, then P+1 CNT cycles).
- Clearing EN during CNT: the FSM is in IDLE at the next edge and COUNT freezes at its current value.
- IM=0 masks the output only. The flag still sets, and setting IM later raises `irq` on the next edge if the flag is still set.

## Test plan
- Reset: pulse `reset` asynchronously mid-cycle → `irq`=0 and `rdata`=0 at CTRL, PRESET and COUNT immediately, with no clock edge needed.
- One-shot: PRESET=5, then CTRL=32'h9 (EN, mode 0, IM) at E0 → COUNT reads 5 after E2. `irq` rises after E8 and stays high. CTRL reads 32'h8. Writing CTRL=0 drops `irq` after the next edge.
- Auto-reload: PRESET=3, CTRL=32'hB → `irq` pulses for 1 cycle after E6, then every 7 cycles, for 3 periods. EN stays 1.
- Byte enables: PRESET=32'h11223344, then write 32'hAABBCCDD with `byteen`=4'b0101 → PRESET reads 32'h11BB33DD. Writing COUNT leaves it unchanged. An address miss leaves `rdata`=0 and all registers unchanged.
- Disable and mask:
  - Clear EN while COUNT=4 → COUNT freezes at 4 and no `irq` follows.
  - IM=0 one-shot run → `irq` stays 0. Then set IM=1 with no CTRL/PRESET write in between: a CTRL write is itself a clear in one-shot mode, so this check passes only by the same-edge rule, and the bench must confirm that `irq` stays 0.
- Reset mid-count: PRESET=100, enable, assert `reset` at COUNT≈50 → all registers 0 and `irq` 0. After release, the FSM stays in IDLE with COUNT=0.
